// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle control FSM and its datapath.
// master: controller (takes instr fields + zero, drives controls); slave: datapath.
interface multicycle_ctrl_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       illegal_instr;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, funct3, funct7b5, zero,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
        output result_src, alu_src_a, alu_src_b, imm_src, alu_control,
        output illegal_instr, state_dbg
    );

    modport slave (
        output opcode, funct3, funct7b5, zero,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
        input  result_src, alu_src_a, alu_src_b, imm_src, alu_control,
        input  illegal_instr, state_dbg
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM plus ALU/immediate decoders for the multicycle RISC-V core.
// Ports: clk, reset (sync, active-high), bus (multicycle_ctrl_if.master).
module multicycle_ctrl #(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] AOP_ADD = 2'b00;
    localparam logic [1:0] AOP_SUB = 2'b01;
    localparam logic [1:0] AOP_FN  = 2'b10;

    state_t state;
    logic   legal;

    assign legal = (bus.opcode == OP_LW) || (bus.opcode == OP_SW)
                || (bus.opcode == OP_R)  || (bus.opcode == OP_I)
                || (bus.opcode == OP_BEQ) || (bus.opcode == OP_JAL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            unique case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    unique case (bus.opcode)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_R:         state <= S_EXECUTER;
                        OP_I:         state <= S_EXECUTEI;
                        OP_BEQ:       state <= S_BEQ;
                        OP_JAL:       state <= S_JAL;
                        default:      state <= ILLEGAL_HALT ? S_HALT : S_FETCH;
                    endcase
                end
                S_MEMADR:   state <= bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: state <= S_FETCH;
                S_EXECUTER: state <= S_ALUWB;
                S_EXECUTEI: state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BEQ:      state <= S_FETCH;
                S_JAL:      state <= S_ALUWB;
                S_HALT:     state <= S_HALT;
                default:    state <= S_FETCH;
            endcase
        end
    end

    logic       pc_update;
    logic       branch;
    logic [1:0] alu_op;
    logic [2:0] fn_ctl;

    // Moore decode; reset forces everything low so no partial writes leak.
    always_comb begin
        pc_update         = 1'b0;
        branch            = 1'b0;
        alu_op            = AOP_ADD;
        bus.adr_src       = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_write     = 1'b0;
        bus.result_src    = 2'b00;
        bus.alu_src_a     = 2'b00;
        bus.alu_src_b     = 2'b00;
        bus.illegal_instr = 1'b0;
        if (!reset) begin
            unique case (state)
                S_FETCH: begin
                    bus.ir_write   = 1'b1;
                    bus.alu_src_b  = 2'b10;
                    bus.result_src = 2'b10;
                    pc_update      = 1'b1;
                end
                S_DECODE: begin
                    bus.alu_src_a     = 2'b01;
                    bus.alu_src_b     = 2'b01;
                    bus.illegal_instr = !legal;
                end
                S_MEMADR: begin
                    bus.alu_src_a = 2'b10;
                    bus.alu_src_b = 2'b01;
                end
                S_MEMREAD: bus.adr_src = 1'b1;
                S_MEMWB: begin
                    bus.result_src = 2'b01;
                    bus.reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    bus.adr_src   = 1'b1;
                    bus.mem_write = 1'b1;
                end
                S_EXECUTER: begin
                    bus.alu_src_a = 2'b10;
                    alu_op        = AOP_FN;
                end
                S_EXECUTEI: begin
                    bus.alu_src_a = 2'b10;
                    bus.alu_src_b = 2'b01;
                    alu_op        = AOP_FN;
                end
                S_ALUWB: bus.reg_write = 1'b1;
                S_BEQ: begin
                    bus.alu_src_a = 2'b10;
                    alu_op        = AOP_SUB;
                    branch        = 1'b1;
                end
                S_JAL: begin
                    bus.alu_src_a = 2'b01;
                    bus.alu_src_b = 2'b10;
                    pc_update     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Only R-type (opcode[5]=1) may turn f3=000 into sub; addi ignores bit 30.
    always_comb begin
        unique case (bus.funct3)
            3'b000:  fn_ctl = (bus.opcode[5] & bus.funct7b5) ? 3'b001 : 3'b000;
            3'b010:  fn_ctl = 3'b101;
            3'b110:  fn_ctl = 3'b011;
            3'b111:  fn_ctl = 3'b010;
            default: fn_ctl = 3'b000;
        endcase
    end

    always_comb begin
        unique case (alu_op)
            AOP_SUB: bus.alu_control = 3'b001;
            AOP_FN:  bus.alu_control = fn_ctl;
            default: bus.alu_control = 3'b000;
        endcase
    end

    always_comb begin
        bus.imm_src = 2'b00;
        if (!reset && state != S_HALT) begin
            unique case (bus.opcode)
                OP_SW:   bus.imm_src = 2'b01;
                OP_BEQ:  bus.imm_src = 2'b10;
                OP_JAL:  bus.imm_src = 2'b11;
                default: bus.imm_src = 2'b00;
            endcase
        end
    end

    assign bus.pc_write  = pc_update | (branch & bus.zero);
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl against a per-instruction phase model.
// Runs one DUT with ILLEGAL_HALT=0 and one with ILLEGAL_HALT=1 on shared stimulus.
module tb_multicycle_ctrl;
    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic [1:0] rs;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] imm;
        logic [2:0] alu;
        logic       ill;
    } cw_t;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;

    localparam int P_F = 0, P_D = 1, P_ADDR = 2, P_RD = 3, P_LWB = 4;
    localparam int P_WR = 5, P_EX = 6, P_WB = 7, P_BR = 8, P_J = 9;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [6:0] op = 7'h0;
    logic [2:0] f3 = 3'h0;
    logic f7 = 1'b0;
    logic z = 1'b0;
    int nchk = 0;
    int npass = 0;
    bit halted1 = 1'b0;

    always #5 clk = ~clk;

    multicycle_ctrl_if bus0 ();
    multicycle_ctrl_if bus1 ();

    assign bus0.opcode = op;
    assign bus0.funct3 = f3;
    assign bus0.funct7b5 = f7;
    assign bus0.zero = z;
    assign bus1.opcode = op;
    assign bus1.funct3 = f3;
    assign bus1.funct7b5 = f7;
    assign bus1.zero = z;

    multicycle_ctrl #(.ILLEGAL_HALT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    multicycle_ctrl #(.ILLEGAL_HALT(1'b1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    cw_t obs0, obs1;
    assign obs0 = {bus0.pc_write, bus0.adr_src, bus0.mem_write,
                   bus0.ir_write, bus0.reg_write, bus0.result_src,
                   bus0.alu_src_a, bus0.alu_src_b, bus0.imm_src,
                   bus0.alu_control, bus0.illegal_instr};
    assign obs1 = {bus1.pc_write, bus1.adr_src, bus1.mem_write,
                   bus1.ir_write, bus1.reg_write, bus1.result_src,
                   bus1.alu_src_a, bus1.alu_src_b, bus1.imm_src,
                   bus1.alu_control, bus1.illegal_instr};

    function automatic bit is_legal(input logic [6:0] o);
        return o == LW || o == SW || o == RT || o == IT || o == BQ || o == JL;
    endfunction

    function automatic int n_cycles(input logic [6:0] o);
        if (o == LW) return 5;
        if (o == SW || o == RT || o == IT || o == JL) return 4;
        if (o == BQ) return 3;
        return 2;
    endfunction

    function automatic int phase(input logic [6:0] o, input int s);
        if (s == 0) return P_F;
        if (s == 1) return P_D;
        if (o == LW) return (s == 2) ? P_ADDR : (s == 3) ? P_RD : P_LWB;
        if (o == SW) return (s == 2) ? P_ADDR : P_WR;
        if (o == RT || o == IT) return (s == 2) ? P_EX : P_WB;
        if (o == BQ) return P_BR;
        return (s == 2) ? P_J : P_WB;
    endfunction

    // ALU operation an R/I instruction asks for, by mnemonic rules.
    function automatic logic [2:0] alu_fn(input logic [6:0] o,
                                          input logic [2:0] f,
                                          input logic fb);
        if (f == 3'b010) return 3'b101;
        if (f == 3'b110) return 3'b011;
        if (f == 3'b111) return 3'b010;
        if (f == 3'b000 && o == RT && fb) return 3'b001;
        return 3'b000;
    endfunction

    function automatic cw_t model(input logic [6:0] o, input logic [2:0] f,
                                  input logic fb, input logic zz,
                                  input int s);
        cw_t c;
        c = '0;
        c.imm = (o == SW) ? 2'd1 : (o == BQ) ? 2'd2 : (o == JL) ? 2'd3 : 2'd0;
        case (phase(o, s))
            P_F: begin
                c.irw = 1'b1; c.b = 2'd2; c.rs = 2'd2; c.pcw = 1'b1;
            end
            P_D: begin
                c.a = 2'd1; c.b = 2'd1; c.ill = !is_legal(o);
            end
            P_ADDR: begin
                c.a = 2'd2; c.b = 2'd1;
            end
            P_RD: c.adr = 1'b1;
            P_LWB: begin
                c.rs = 2'd1; c.rw = 1'b1;
            end
            P_WR: begin
                c.adr = 1'b1; c.mw = 1'b1;
            end
            P_EX: begin
                c.a = 2'd2; c.b = (o == RT) ? 2'd0 : 2'd1;
                c.alu = alu_fn(o, f, fb);
            end
            P_WB: c.rw = 1'b1;
            P_BR: begin
                c.a = 2'd2; c.alu = 3'b001; c.pcw = zz;
            end
            P_J: begin
                c.a = 2'd1; c.b = 2'd2; c.pcw = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    task automatic check(input cw_t got, input cw_t exp, input string tag);
        nchk++;
        assert (got === exp) npass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // zmode: 0/1 force the zero flag, 2 randomizes it every cycle.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f,
                             input logic fb, input int zmode, input int nlim);
        cw_t e;
        int n;
        n = n_cycles(o);
        if (nlim < n) n = nlim;
        for (int s = 0; s < n; s++) begin
            @(posedge clk);
            #1;
            if (s == 0) begin
                op = o; f3 = f; f7 = fb; reset = 1'b0;
            end
            z = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #2;
            e = model(o, f, fb, z, s);
            check(obs0, e, $sformatf("op%h step%0d", o, s));
            check(obs1, halted1 ? cw_t'('0) : e,
                  $sformatf("halt op%h step%0d", o, s));
        end
        if (!is_legal(o) && n == n_cycles(o)) halted1 = 1'b1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            reset = 1'b1;
            op = 7'($urandom);
            z = 1'($urandom_range(0, 1));
            #2;
            check(obs0, '0, "reset0");
            check(obs1, '0, "reset1");
        end
        halted1 = 1'b0;
    endtask

    function automatic logic [6:0] rand_op(input bit allow_ill);
        logic [6:0] t;
        int k;
        k = allow_ill ? $urandom_range(0, 6) : $urandom_range(0, 5);
        case (k)
            0: t = LW;
            1: t = SW;
            2: t = RT;
            3: t = IT;
            4: t = BQ;
            5: t = JL;
            default: begin
                t = 7'($urandom);
                while (is_legal(t)) t = 7'($urandom);
            end
        endcase
        return t;
    endfunction

    initial begin
        do_reset(2);
        run_instr(LW, 3'd2, 1'b0, 2, 99);
        run_instr(SW, 3'd2, 1'b0, 2, 99);
        run_instr(RT, 3'd0, 1'b1, 2, 99);
        run_instr(RT, 3'd0, 1'b0, 2, 99);
        run_instr(IT, 3'd0, 1'b1, 2, 99);
        run_instr(RT, 3'd7, 1'b0, 2, 99);
        run_instr(IT, 3'd6, 1'b0, 2, 99);
        run_instr(IT, 3'd2, 1'b0, 2, 99);
        run_instr(RT, 3'd4, 1'b1, 2, 99);
        run_instr(BQ, 3'd0, 1'b0, 1, 99);
        run_instr(BQ, 3'd0, 1'b0, 0, 99);
        run_instr(JL, 3'd0, 1'b0, 2, 99);
        run_instr(LW, 3'd2, 1'b0, 1, 3);
        do_reset(2);
        run_instr(SW, 3'd2, 1'b0, 2, 3);
        do_reset(1);
        run_instr(JL, 3'd0, 1'b0, 2, 99);
        run_instr(7'h7F, 3'd0, 1'b0, 2, 99);
        run_instr(RT, 3'd0, 1'b1, 2, 99);
        run_instr(LW, 3'd0, 1'b0, 2, 99);
        do_reset(2);
        run_instr(BQ, 3'd0, 1'b0, 1, 99);
        for (int i = 0; i < 120; i++) begin
            run_instr(rand_op(1'b1), 3'($urandom), 1'($urandom), 2, 99);
            if ($urandom_range(0, 15) == 0) do_reset($urandom_range(1, 2));
        end
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
